seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed N-digit 7-segment scan driver. It keeps a
//            double-buffered digit image that is committed only at frame
//            boundaries. It decodes each digit as hex or BCD, suppresses
//            leading zeros and holds every anode off for a guard interval
//            at the start of each slot so the display does not ghost.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 2,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_suppress,
  input  logic                  load,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_done
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0]       C_PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]       C_IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0]       C_GUARD      = PW'(GUARD);
  localparam logic [6:0]          C_SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                C_DP_OFF     = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [N_DIGITS-1:0] C_AN_OFF     = (AN_ACTIVE_LOW != 0) ?
                                                 {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  // --------------------------------------------------------------------------
  // Digit code to lit-segment set (bit0 = a .. bit6 = g, 1 = lit)
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] lit;
    case (code)
      4'h0:    lit = 7'h3F;
      4'h1:    lit = 7'h06;
      4'h2:    lit = 7'h5B;
      4'h3:    lit = 7'h4F;
      4'h4:    lit = 7'h66;
      4'h5:    lit = 7'h6D;
      4'h6:    lit = 7'h7D;
      4'h7:    lit = 7'h07;
      4'h8:    lit = 7'h7F;
      4'h9:    lit = 7'h6F;
      4'hA:    lit = 7'h77;
      4'hB:    lit = 7'h7C;
      4'hC:    lit = 7'h39;
      4'hD:    lit = 7'h5E;
      4'hE:    lit = 7'h79;
      4'hF:    lit = 7'h71;
      default: lit = 7'h00;
    endcase
    // In decimal mode the letter codes have no glyph and stay dark
    if ((HEX_MODE == 0) && (code > 4'd9)) begin
      lit = 7'h00;
    end
    return lit;
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  frame_done_q;
  logic                  w_slot_end;
  logic                  w_wrap;

  logic [4*N_DIGITS-1:0] disp_code_q, disp_code_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]   disp_blank_q, disp_blank_d;
  logic [4*N_DIGITS-1:0] pend_code_q, pend_code_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                  pend_valid_q, pend_valid_d;

  logic [N_DIGITS-1:0]   w_zero_above;
  logic [N_DIGITS-1:0]   w_idx_onehot;
  logic [3:0]            w_cur_code;
  logic                  w_cur_dp;
  logic                  w_cur_blank;
  logic                  w_cur_zero_above;
  logic                  w_suppress;

  logic [6:0]            w_seg_lit;
  logic                  w_dp_lit;
  logic [N_DIGITS-1:0]   w_an_act;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  // --------------------------------------------------------------------------
  // Scan position
  // --------------------------------------------------------------------------
  assign w_slot_end = (presc_q == C_PRESC_LAST);
  assign w_wrap     = w_slot_end && (idx_q == C_IDX_LAST);

  // Next prescaler / digit index: the index steps once per full slot
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (w_slot_end) begin
      presc_d = '0;
      idx_d   = (idx_q == C_IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Scan state registers; frame_done marks the first cycle of a new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_done_q <= w_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Double buffer: the display image is only rewritten in the frame_done
  // cycle, so a frame is always drawn from a single consistent image.
  // --------------------------------------------------------------------------

  // Decide what the pending and display images hold next
  always_comb begin
    disp_code_d  = disp_code_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_code_d  = pend_code_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    if (frame_done_q) begin
      if (load) begin
        // A load on the boundary itself bypasses the pending stage
        disp_code_d  = data_in;
        disp_dp_d    = dp_in;
        disp_blank_d = blank_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        disp_code_d  = pend_code_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_code_d  = data_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_valid_d = 1'b1;
    end
  end

  // Pending and display image registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_code_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_code_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      disp_code_q  <= disp_code_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_code_q  <= pend_code_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Current digit. The next-state image is used so that a commit in the
  // frame_done cycle is already visible to the first slot of the new frame,
  // even when GUARD is 0.
  // --------------------------------------------------------------------------

  // Flag, per digit, whether it and every more significant digit are zero
  always_comb begin
    logic acc;
    acc          = 1'b1;
    w_zero_above = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc             = acc & (disp_code_d[4*i +: 4] == 4'h0);
      w_zero_above[i] = acc;
    end
  end

  // Select the fields of the digit being scanned
  always_comb begin
    w_cur_code       = 4'h0;
    w_cur_dp         = 1'b0;
    w_cur_blank      = 1'b0;
    w_cur_zero_above = 1'b0;
    w_idx_onehot     = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_cur_code       = disp_code_d[4*i +: 4];
        w_cur_dp         = disp_dp_d[i];
        w_cur_blank      = disp_blank_d[i];
        w_cur_zero_above = w_zero_above[i];
        w_idx_onehot[i]  = 1'b1;
      end
    end
  end

  // Digit 0 always shows, so a value of zero still reads "0"
  assign w_suppress = lz_suppress && (idx_q != '0) && w_cur_zero_above;

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------

  // Lit set for this cycle: dark during guard, blank_in kills dp too,
  // and a suppressed digit keeps its decimal point
  always_comb begin
    w_seg_lit = 7'h00;
    w_dp_lit  = 1'b0;
    w_an_act  = '0;
    if (presc_q >= C_GUARD) begin
      w_an_act = w_idx_onehot;
      if (!w_cur_blank) begin
        w_dp_lit = w_cur_dp;
        if (!w_suppress) begin
          w_seg_lit = f_decode(w_cur_code);
        end
      end
    end
  end

  // Apply the board polarity to the lit sets
  always_comb begin
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~w_seg_lit : w_seg_lit;
    dp_d  = (SEG_ACTIVE_LOW != 0) ? ~w_dp_lit  : w_dp_lit;
    an_d  = (AN_ACTIVE_LOW  != 0) ? ~w_an_act  : w_an_act;
  end

  // Registered pin drivers; reset forces every pin to its inactive level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= C_SEG_OFF;
      dp_q  <= C_DP_OFF;
      an_q  <= C_AN_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
